fbs_ctrl: RTL and testbench

Sequencer for the f-register backup stack (`fbs`). It accepts call, return and flush requests from the CPU control unit and drives the `fbs` backup/restore strobes. It also drives the f-register-file write enable that captures restored data. It tracks stack depth, so overflow and underflow never reach the stack. It sits between the main control FSM and the `fbs` instance.

---
 rtl/fbs_ctrl_if.sv | 27 ++
 rtl/fbs_ctrl.sv | 125 ++++++++++++
 tb/tb_fbs_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fbs_ctrl_if.sv
// Request/status bundle between the CPU control unit and the fbs sequencer.
// The master modport is the requester side; the slave modport is fbs_ctrl.
interface fbs_ctrl_if #(parameter int PTR_W = 5);
  logic             call_req;
  logic             ret_req;
  logic             flush_req;
  logic             err_clr;
  logic             busy;
  logic             done;
  logic             err;
  logic             backup;
  logic             restore;
  logic             freg_we;
  logic [PTR_W-1:0] depth;
  logic             ovf;
  logic             unf;

  modport master (
    output call_req, ret_req, flush_req, err_clr,
    input  busy, done, err, backup, restore, freg_we, depth, ovf, unf
  );

  modport slave (
    input  call_req, ret_req, flush_req, err_clr,
    output busy, done, err, backup, restore, freg_we, depth, ovf, unf
  );
endinterface

// File: rtl/fbs_ctrl.sv
// Sequencer for the f-register backup stack: arbitrates call/ret/flush,
// strobes backup/restore/freg_we and guards the stack against over/underflow.
module fbs_ctrl #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  fbs_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BACKUP,
    S_RESTORE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PTR_W-1:0] r_depth;
  logic [PTR_W-1:0] w_depthNext;
  logic             w_errNext;
  logic             w_ovfSet;
  logic             w_unfSet;

  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_backup;
  logic             r_restore;
  logic             r_fregWe;
  logic             r_ovf;
  logic             r_unf;

  // Arbitration is call > ret > flush; losers simply stay asserted until a later IDLE visit.
  always_comb begin
    w_next      = r_state;
    w_depthNext = r_depth;
    w_errNext   = 1'b0;
    w_ovfSet    = 1'b0;
    w_unfSet    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.call_req) begin
          if (r_depth == PTR_W'(DEPTH)) begin
            w_ovfSet  = 1'b1;
            w_errNext = 1'b1;
            w_next    = S_DONE;
          end else begin
            w_next = S_BACKUP;
          end
        end else if (bus.ret_req) begin
          if (r_depth == '0) begin
            w_unfSet  = 1'b1;
            w_errNext = 1'b1;
            w_next    = S_DONE;
          end else begin
            w_next = S_RESTORE;
          end
        end else if (bus.flush_req) begin
          w_depthNext = '0;
          w_next      = S_DONE;
        end
      end
      S_BACKUP: begin
        w_depthNext = r_depth + PTR_W'(1);
        w_next      = S_DONE;
      end
      S_RESTORE: w_next = S_LOAD;
      S_LOAD: begin
        w_depthNext = r_depth - PTR_W'(1);
        w_next      = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_depth   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_backup  <= 1'b0;
      r_restore <= 1'b0;
      r_fregWe  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_depth   <= w_depthNext;
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_err     <= w_errNext;
      r_backup  <= (w_next == S_BACKUP);
      r_restore <= (w_next == S_RESTORE);
      r_fregWe  <= (w_next == S_LOAD);
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovfSet | (r_ovf & ~bus.err_clr);
      r_unf <= w_unfSet | (r_unf & ~bus.err_clr);
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.backup  = r_backup;
  assign bus.restore = r_restore;
  assign bus.freg_we = r_fregWe;
  assign bus.depth   = r_depth;
  assign bus.ovf     = r_ovf;
  assign bus.unf     = r_unf;

endmodule

// File: tb/tb_fbs_ctrl.sv
// Self-checking bench for fbs_ctrl with a small behavioural fbs stand-in
// and an abstract depth/flag model for randomized call/ret/flush traffic.
module tb_fbs_ctrl;
  localparam int DEPTH = 16;
  localparam int PTR_W = 5;
  localparam int OP_CALL = 0;
  localparam int OP_RET = 1;
  localparam int OP_FLUSH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic [7:0] fbsMem [0:DEPTH-1];
  int fbsPtr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fbs_ctrl_if #(.PTR_W(PTR_W)) bus ();

  fbs_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stand-in for the real fbs: a LIFO written on backup and read on restore.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbsPtr  <= 0;
      dataOut <= '0;
    end else if (bus.backup && fbsPtr < DEPTH) begin
      fbsMem[fbsPtr] <= dataIn;
      fbsPtr         <= fbsPtr + 1;
    end else if (bus.restore && fbsPtr > 0) begin
      dataOut <= fbsMem[fbsPtr-1];
      fbsPtr  <= fbsPtr - 1;
    end
  end

  task automatic doReset();
    rst_n         = 1'b0;
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.flush_req = 1'b0;
    bus.err_clr   = 1'b0;
    dataIn        = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one request from IDLE and records what happens until done (or a cycle budget expires).
  task automatic applyStimulus(input int op, input logic [7:0] din, output int lat,
                               output int nB, output int nR, output int nW, output bit errSeen,
                               output bit overlap, output bit timeout, output logic [7:0] wData);
    int k;
    bit gotDone;
    nB = 0; nR = 0; nW = 0; lat = 0;
    errSeen = 0; overlap = 0; timeout = 0; gotDone = 0; wData = '0;
    @(negedge clk);
    k = 0;
    while (bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    dataIn = din;
    case (op)
      OP_CALL: bus.call_req = 1'b1;
      OP_RET:  bus.ret_req = 1'b1;
      default: bus.flush_req = 1'b1;
    endcase
    k = 0;
    while (!gotDone && k < 12) begin
      @(negedge clk);
      k++;
      if (bus.backup) nB++;
      if (bus.restore) nR++;
      if (bus.freg_we) begin
        nW++;
        wData = dataOut;
      end
      if (int'(bus.backup) + int'(bus.restore) + int'(bus.freg_we) > 1) overlap = 1;
      if (bus.done) begin
        gotDone = 1;
        lat = k;
        errSeen = bus.err;
      end
    end
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.flush_req = 1'b0;
    if (!gotDone) timeout = 1;
  endtask

  task automatic test_reset();
    int lat, nB, nR, nW;
    bit e, ov, to;
    logic [7:0] wd;
    rst_n = 1'b0;
    bus.call_req = 0; bus.ret_req = 0; bus.flush_req = 0; bus.err_clr = 0;
    dataIn = '0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.backup, bus.restore, bus.freg_we, bus.ovf, bus.unf} !== 8'h00
        || bus.depth !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b depth=%0d required all 0", bus.busy, bus.done, bus.depth);
    end
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(OP_CALL, 8'h00, lat, nB, nR, nW, e, ov, to, wd);
    @(negedge clk);
    bus.call_req = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.backup !== 1'b1 || bus.depth !== PTR_W'(3)) begin
      errors++;
      $display("[TB] FAIL pre_reset_backup: got backup=%b depth=%0d required 1 and 3", bus.backup, bus.depth);
    end
    rst_n = 1'b0;
    bus.call_req = 1'b0;
    #1;
    checks++;
    if (bus.backup !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.depth !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got backup=%b busy=%b done=%b depth=%0d required 0", bus.backup, bus.busy, bus.done, bus.depth);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int lat, nB, nR, nW, cnt;
    bit e, ov, to;
    logic [7:0] wd;
    doReset();
    applyStimulus(OP_CALL, 8'h5A, lat, nB, nR, nW, e, ov, to, wd);
    @(negedge clk);
    bus.ret_req = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.restore !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_restore: got restore=%b required 1", bus.restore);
    end
    rst_n = 1'b0;
    bus.ret_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.freg_we || bus.done) cnt++;
    end
    checks++;
    if (cnt != 0 || bus.depth !== '0) begin
      errors++;
      $display("[TB] FAIL abort_no_load: got %0d freg_we/done cycles depth=%0d required 0 and 0", cnt, bus.depth);
    end
  endtask

  task automatic test_overflow();
    int lat, nB, nR, nW;
    bit e, ov, to;
    logic [7:0] wd;
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_CALL, 8'(i), lat, nB, nR, nW, e, ov, to, wd);
      checks++;
      if (to || lat != 2 || nB != 1 || e || ov || bus.depth !== PTR_W'(i + 1)) begin
        errors++;
        $display("[TB] FAIL call_%0d: got lat=%0d backups=%0d err=%b depth=%0d timeout=%b required 2,1,0,%0d,0",
                 i, lat, nB, e, bus.depth, to, i + 1);
      end
    end
    applyStimulus(OP_CALL, 8'hFF, lat, nB, nR, nW, e, ov, to, wd);
    checks++;
    if (to || lat != 1 || nB != 0 || !e || bus.ovf !== 1'b1 || bus.depth !== PTR_W'(DEPTH)) begin
      errors++;
      $display("[TB] FAIL overflow: got lat=%0d backups=%0d err=%b ovf=%b depth=%0d required 1,0,1,1,16",
               lat, nB, e, bus.ovf, bus.depth);
    end
  endtask

  task automatic test_data_order();
    int lat, nB, nR, nW;
    bit e, ov, to;
    logic [7:0] wd;
    logic [7:0] expQ[$];
    logic [7:0] exp;
    doReset();
    for (int v = 15; v >= 1; v--) begin
      applyStimulus(OP_CALL, 8'(v), lat, nB, nR, nW, e, ov, to, wd);
      expQ.push_back(8'(v));
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(OP_RET, 8'h00, lat, nB, nR, nW, e, ov, to, wd);
      exp = expQ.pop_back();
      checks++;
      if (to || lat != 3 || nR != 1 || nW != 1 || e || ov || wd !== exp) begin
        errors++;
        $display("[TB] FAIL ret_data_%0d: got lat=%0d restores=%0d loads=%0d data=%0d required 3,1,1,%0d",
                 i, lat, nR, nW, wd, exp);
      end
    end
    checks++;
    if (bus.depth !== '0) begin
      errors++;
      $display("[TB] FAIL depth_after_pops: got %0d required 0", bus.depth);
    end
  endtask

  task automatic test_underflow_clear();
    int lat, nB, nR, nW;
    bit e, ov, to;
    logic [7:0] wd;
    applyStimulus(OP_RET, 8'h00, lat, nB, nR, nW, e, ov, to, wd);
    checks++;
    if (to || lat != 1 || !e || nR != 0 || bus.unf !== 1'b1 || bus.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow: got lat=%0d err=%b restores=%0d unf=%b ovf=%b required 1,1,0,1,0",
               lat, e, nR, bus.unf, bus.ovf);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.unf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clr: got unf=%b required 0", bus.unf);
    end
    @(negedge clk);
    bus.err_clr = 1'b1;
    bus.ret_req = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.unf !== 1'b1 || bus.done !== 1'b1 || bus.err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins: got unf=%b done=%b err=%b required 1,1,1", bus.unf, bus.done, bus.err);
    end
    bus.ret_req = 1'b0;
  endtask

  task automatic test_priority();
    int lat, nB, nR, nW, nDone, k;
    bit e, ov, to, overlap;
    logic [7:0] wd;
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(OP_CALL, 8'(i), lat, nB, nR, nW, e, ov, to, wd);
    @(negedge clk);
    bus.call_req = 1'b1;
    bus.ret_req  = 1'b1;
    nDone = 0; overlap = 0; k = 0;
    while (nDone < 2 && k < 20) begin
      @(negedge clk);
      k++;
      if (int'(bus.backup) + int'(bus.restore) + int'(bus.freg_we) > 1) overlap = 1;
      if (bus.done) begin
        nDone++;
        checks++;
        if (bus.depth !== PTR_W'(nDone == 1 ? 4 : 3) || bus.err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL priority_done_%0d: got depth=%0d err=%b required %0d,0",
                   nDone, bus.depth, bus.err, nDone == 1 ? 4 : 3);
        end
        if (nDone == 1) bus.call_req = 1'b0;
        else bus.ret_req = 1'b0;
      end
    end
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) nDone++;
    end
    checks++;
    if (nDone != 2 || overlap) begin
      errors++;
      $display("[TB] FAIL priority_pulses: got done=%0d overlap=%b required 2,0", nDone, overlap);
    end
  endtask

  task automatic test_flush();
    int lat, nB, nR, nW;
    bit e, ov, to;
    logic [7:0] wd;
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(OP_CALL, 8'(i), lat, nB, nR, nW, e, ov, to, wd);
    applyStimulus(OP_FLUSH, 8'h00, lat, nB, nR, nW, e, ov, to, wd);
    checks++;
    if (to || lat != 1 || e || nB + nR + nW != 0 || bus.depth !== '0) begin
      errors++;
      $display("[TB] FAIL flush: got lat=%0d err=%b strobes=%0d depth=%0d required 1,0,0,0",
               lat, e, nB + nR + nW, bus.depth);
    end
    applyStimulus(OP_RET, 8'h00, lat, nB, nR, nW, e, ov, to, wd);
    checks++;
    if (to || !e || bus.unf !== 1'b1 || nR != 0) begin
      errors++;
      $display("[TB] FAIL flush_then_ret: got err=%b unf=%b restores=%0d required 1,1,0", e, bus.unf, nR);
    end
  endtask

  // Reference model: depth as a plain integer, flags as bits, latency/strobes from the op rules.
  task automatic test_random();
    int lat, nB, nR, nW, op, r, mDepth, eLat, eB, eR;
    bit e, ov, to, mOvf, mUnf, eErr;
    logic [7:0] wd;
    doReset();
    mDepth = 0; mOvf = 0; mUnf = 0;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 6) ? OP_CALL : (r < 9) ? OP_RET : OP_FLUSH;
      eB = 0; eR = 0; eErr = 0;
      if (op == OP_CALL) begin
        if (mDepth == DEPTH) begin eErr = 1; mOvf = 1; eLat = 1; end
        else begin eB = 1; eLat = 2; mDepth++; end
      end else if (op == OP_RET) begin
        if (mDepth == 0) begin eErr = 1; mUnf = 1; eLat = 1; end
        else begin eR = 1; eLat = 3; mDepth--; end
      end else begin
        eLat = 1; mDepth = 0;
      end
      applyStimulus(op, 8'($urandom), lat, nB, nR, nW, e, ov, to, wd);
      checks++;
      if (to || ov || lat != eLat || e != eErr || nB != eB || nR != eR || nW != eR
          || bus.depth !== PTR_W'(mDepth) || bus.ovf !== mOvf || bus.unf !== mUnf) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d: got lat=%0d err=%b b/r/w=%0d/%0d/%0d depth=%0d ovf=%b unf=%b required %0d,%b,%0d/%0d/%0d,%0d,%b,%b",
                 i, op, lat, e, nB, nR, nW, bus.depth, bus.ovf, bus.unf, eLat, eErr, eB, eR, eR, mDepth, mOvf, mUnf);
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        mOvf = 0; mUnf = 0;
        checks++;
        if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
          errors++;
          $display("[TB] FAIL random_clr_%0d: got ovf=%b unf=%b required 0,0", i, bus.ovf, bus.unf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_overflow();
    test_data_order();
    test_underflow_clear();
    test_priority();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
